cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
- Shares the single RAM port between Icache line refills and Dcache line refills/writebacks.
- Grants one requester at a time and sequences a LINE_WORDS-beat burst with a word counter.
- Returns read beats to the granted requester and signals completion with a one-cycle done pulse.
- Sits between the Icache/Dcache miss logic and the RAM model used by the CPU testbench.

Parameters:
- LINE_WORDS, 4, words per cache line; power of two, minimum 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ic_req  in  1  Icache refill request; held high until ic_done.
- ic_addr  in  ADDR_W  Icache miss byte address.
- ic_rdata  out  32  refill word.
- ic_rvalid  out  1  ic_rdata valid this cycle.
- ic_done  out  1  one-cycle pulse, Icache burst finished.
- dc_req  in  1  Dcache request; held high until dc_done.
- dc_we  in  1  1 = line writeback, 0 = line refill; stable while dc_req is high.
- dc_addr  in  ADDR_W  Dcache byte address.
- dc_wdata  in  32  current writeback word (word index = beats already accepted).
- dc_wnext  out  1  current dc_wdata consumed; Dcache advances to the next word.
- dc_rdata  out  32  refill word.
- dc_rvalid  out  1  dc_rdata valid this cycle.
- dc_done  out  1  one-cycle pulse, Dcache burst finished.
- ram_addr  out  ADDR_W  word address of the current beat.
- ram_re  out  1  read beat pending.
- ram_we  out  1  write beat pending.
- ram_wdata  out  32  write data.
- ram_rdata  in  32  read data, valid when ram_ready=1.
- ram_ready  in  1  RAM completes the pending beat this cycle.

Behaviour:
- Reset: synchronous, active-high, on clk rising edge.
  - All outputs 0; state=IDLE; cnt=0; base=0; last_grant=IC.
  - Takes effect mid-burst: the beat in flight is abandoned and no done pulse is issued.
- States: IDLE, IC_RD, DC_RD, DC_WR, DONE.
- IDLE:
  - If dc_req or ic_req is high at the clock edge, latch base = addr with bits [log2(LINE_WORDS)+1:0] cleared, cnt=0, and record owner.
  - Next state: DC_WR if dc is granted with dc_we=1, DC_RD if dc_we=0, IC_RD if ic is granted.
  - No request: stay in IDLE.
- Burst states:
  - ram_addr = base + 4*cnt (registered path, no combinational input dependence).
  - ram_re=1 in IC_RD/DC_RD; ram_we=1 in DC_WR; ram_wdata = dc_wdata (combinational).
  - When ram_ready=1: cnt increments.
  - Read beat: owner's rdata <= ram_rdata and rvalid <= 1 for exactly one cycle on the following cycle.
  - Write beat: dc_wnext = ram_ready & (state==DC_WR), combinational, same cycle as ram_ready.
  - ram_ready=0: hold the beat (address and strobes stable); no limit on wait cycles.
  - Last beat (cnt==LINE_WORDS-1 && ram_ready): next state DONE; ram_re/ram_we deassert from that next cycle; cnt wraps to 0.
- DONE:
  - Owner's done=1 for one cycle; for reads this coincides with the last rvalid.
  - last_grant <= owner; next state IDLE.
  - Requester must drop req in the cycle it sees done; a req still high in the IDLE cycle after DONE is treated as a new request.
- Latency: req sampled at edge N → first ram strobe in cycle N+1 → with ram_ready constantly 1, done in cycle N+1+LINE_WORDS.
- Arbitration, ties in IDLE: fixed priority, Dcache wins (refill/writeback stalls the memory stage).
- A request arriving during a burst waits; the other requester is never preempted.
- ram_ready while in IDLE or DONE is ignored.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: tie in IDLE is resolved round-robin, granting the requester opposite last_grant. last_grant resets to IC, so the first tie goes to Dcache.
- Undefined: fixed Dcache priority; last_grant is unused and may be optimised away.
- Single requests behave identically in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles with both req high → all outputs 0, no ram_re/ram_we. After release, the first grant is Dcache.
- Icache refill: ic_addr=0x0000_1234, ram_ready=1 constant →
  - ram_addr 0x1230, 0x1234, 0x1238, 0x123C on 4 consecutive cycles.
  - ic_rvalid on 4 consecutive cycles with the returned data in order.
  - ic_done exactly once, together with the 4th rvalid.
- Dcache writeback: dc_addr=0x2000, dc_we=1, words 0xA0..0xA3, ram_ready every other cycle →
  - ram_we held for 8 cycles.
  - ram_wdata/ram_addr pairs (0x2000,0xA0)…(0x200C,0xA3).
  - dc_wnext 4 pulses, one per ram_ready; then dc_done.
- Tie: ic_req and dc_req rise together →
  - Dcache burst runs first.
  - Icache burst starts 1 cycle after the IDLE following dc_done.
  - No beats interleave between the two bursts.
- Reset mid-burst: rst after the 2nd beat of an Icache refill →
  - Next cycle ram_re=0, ic_done never pulses.
  - A re-issued request restarts at the base address with word 0.
- ARB_RR_EN: both requesters re-request immediately after each done, 4 bursts → grant order DC, IC, DC, IC. Without the macro the order is DC, DC, DC, DC.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares one RAM port between Icache line refills and Dcache line
// refills/writebacks. One requester owns the port at a time. Its LINE_WORDS-beat
// burst is sequenced with a word counter and finishes with a one-cycle done pulse.
// Read beats return to the owner one cycle after the RAM completes them.
//
// Build option: define ARB_RR_EN to resolve simultaneous requests round-robin.
// The grant then goes to the requester opposite the last one served.
// Without it, the Dcache always wins a tie.
module cache_mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  // Icache refill side
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [31:0]       ic_rdata,
  output logic              ic_rvalid,
  output logic              ic_done,
  // Dcache refill/writeback side
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [31:0]       dc_wdata,
  output logic              dc_wnext,
  output logic [31:0]       dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_done,
  // RAM port
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ready
);

  // Word counter width and the byte-offset bits cleared to form a line base
  localparam int                CNT_W    = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * 32'd4 - 32'd1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LINE_WORDS - 32'd1);

  // Burst owner encoding
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IC_RD = 3'd1,
    DC_RD = 3'd2,
    DC_WR = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] base_r;
  logic              owner_r;
`ifdef ARB_RR_EN
  logic              last_grant_r;
`endif

  // Registered outputs
  logic [ADDR_W-1:0] ram_addr_r;
  logic              ram_re_r;
  logic              ram_we_r;
  logic [31:0]       ic_rdata_r;
  logic              ic_rvalid_r;
  logic              ic_done_r;
  logic [31:0]       dc_rdata_r;
  logic              dc_rvalid_r;
  logic              dc_done_r;

  // Combinational helpers
  logic [ADDR_W-1:0] ic_line_s;
  logic [ADDR_W-1:0] dc_line_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic              last_beat_s;
  logic              grant_ic_s;
  logic              grant_dc_s;

  // Line-aligned request addresses and the address of the following beat
  always_comb begin
    ic_line_s   = ic_addr & ~OFF_MASK;
    dc_line_s   = dc_addr & ~OFF_MASK;
    cnt_inc_s   = cnt_r + CNT_W'(32'd1);
    // cnt_inc_s wraps to 0 after the last word, so this returns to the base
    next_addr_s = base_r + ADDR_W'({cnt_inc_s, 2'b00});
    last_beat_s = (cnt_r == LAST_CNT);
  end

  // Arbitration between the two requesters, only acted on in IDLE
  always_comb begin
    grant_ic_s = 1'b0;
    grant_dc_s = 1'b0;
    if (dc_req && ic_req) begin
`ifdef ARB_RR_EN
      // Alternate on a tie; last_grant resets to IC so the first tie goes to DC
      if (last_grant_r == OWN_DC) begin
        grant_ic_s = 1'b1;
      end else begin
        grant_dc_s = 1'b1;
      end
`else
      // Dcache stalls the memory stage, so it wins ties
      grant_dc_s = 1'b1;
`endif
    end else if (dc_req) begin
      grant_dc_s = 1'b1;
    end else if (ic_req) begin
      grant_ic_s = 1'b1;
    end else begin
      grant_ic_s = 1'b0;
      grant_dc_s = 1'b0;
    end
  end

  // Write data passes straight through during a writeback.
  // The Dcache advances its word pointer in the cycle the RAM takes a beat.
  always_comb begin
    if (state_r == DC_WR) begin
      ram_wdata = dc_wdata;
      dc_wnext  = ram_ready;
    end else begin
      ram_wdata = 32'd0;
      dc_wnext  = 1'b0;
    end
  end

  // Burst state machine with registered RAM strobes, read returns and done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      base_r       <= {ADDR_W{1'b0}};
      owner_r      <= OWN_IC;
`ifdef ARB_RR_EN
      last_grant_r <= OWN_IC;
`endif
      ram_addr_r   <= {ADDR_W{1'b0}};
      ram_re_r     <= 1'b0;
      ram_we_r     <= 1'b0;
      ic_rdata_r   <= 32'd0;
      ic_rvalid_r  <= 1'b0;
      ic_done_r    <= 1'b0;
      dc_rdata_r   <= 32'd0;
      dc_rvalid_r  <= 1'b0;
      dc_done_r    <= 1'b0;
    end else begin
      // Valid and done are single-cycle pulses unless re-armed below
      ic_rvalid_r <= 1'b0;
      dc_rvalid_r <= 1'b0;
      ic_done_r   <= 1'b0;
      dc_done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (grant_dc_s) begin
            base_r     <= dc_line_s;
            ram_addr_r <= dc_line_s;
            owner_r    <= OWN_DC;
            if (dc_we) begin
              state_r  <= DC_WR;
              ram_we_r <= 1'b1;
            end else begin
              state_r  <= DC_RD;
              ram_re_r <= 1'b1;
            end
          end else if (grant_ic_s) begin
            base_r     <= ic_line_s;
            ram_addr_r <= ic_line_s;
            owner_r    <= OWN_IC;
            state_r    <= IC_RD;
            ram_re_r   <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        IC_RD, DC_RD, DC_WR: begin
          // With ram_ready low the beat simply holds; address and strobes are stable
          if (ram_ready) begin
            cnt_r      <= cnt_inc_s;
            ram_addr_r <= next_addr_s;
            if (state_r == IC_RD) begin
              ic_rdata_r  <= ram_rdata;
              ic_rvalid_r <= 1'b1;
            end else if (state_r == DC_RD) begin
              dc_rdata_r  <= ram_rdata;
              dc_rvalid_r <= 1'b1;
            end else begin
              ic_rvalid_r <= 1'b0;
              dc_rvalid_r <= 1'b0;
            end
            if (last_beat_s) begin
              state_r  <= DONE;
              ram_re_r <= 1'b0;
              ram_we_r <= 1'b0;
              // Done is raised here so it lines up with the last read return
              if (owner_r == OWN_DC) begin
                dc_done_r <= 1'b1;
              end else begin
                ic_done_r <= 1'b1;
              end
            end else begin
              state_r <= state_r;
            end
          end else begin
            state_r <= state_r;
          end
        end
        DONE: begin
`ifdef ARB_RR_EN
          last_grant_r <= owner_r;
`endif
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          ram_re_r <= 1'b0;
          ram_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign ram_addr  = ram_addr_r;
  assign ram_re    = ram_re_r;
  assign ram_we    = ram_we_r;
  assign ic_rdata  = ic_rdata_r;
  assign ic_rvalid = ic_rvalid_r;
  assign ic_done   = ic_done_r;
  assign dc_rdata  = dc_rdata_r;
  assign dc_rvalid = dc_rvalid_r;
  assign dc_done   = dc_done_r;

endmodule
